// File: rtl/count_stream_checker.sv
// Checks that a sampled count bus advances by one (mod 2^WIDTH) per valid sample.
// It locks onto the sequence, counts mismatches while locked, and drops lock after repeated misses.
module count_stream_checker #(
   parameter int WIDTH    = 8,
   parameter int ERR_W    = 8,
   parameter int LOCK_LEN = 4,
   parameter int LOSS_LEN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] expected,
   output logic [1:0]       state
);

   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_ACQUIRE = 2'd1;
   localparam logic [1:0] S_LOCKED  = 2'd2;

   localparam logic [WIDTH-1:0] DATA_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [3:0]       LOCK_C   = 4'(LOCK_LEN);
   localparam logic [3:0]       LOSS_C   = 4'(LOSS_LEN);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       miss_q, miss_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             err_pulse_q, err_pulse_d;

   logic accept;
   logic match;

   // Handshake: a sample is consumed only when enable and in_valid are high and clear is low.
   assign accept = enable & in_valid & ~clear;
   assign match  = (in_data == expected_q);

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      run_d       = run_q;
      miss_d      = miss_q;
      err_count_d = err_count_q;
      err_pulse_d = 1'b0;

      if (clear) begin
         state_d     = S_SEARCH;
         err_count_d = '0;
         run_d       = '0;
         miss_d      = '0;
      end else if (state_q == 2'd3) begin
         state_d = S_SEARCH;
      end else if (accept) begin
         case (state_q)
            S_SEARCH: begin
               expected_d = in_data + DATA_ONE;
               run_d      = 4'd1;
               state_d    = S_ACQUIRE;
            end
            S_ACQUIRE: begin
               expected_d = in_data + DATA_ONE;
               if (match) begin
                  run_d = run_q + 4'd1;
                  if (run_q + 4'd1 == LOCK_C) begin
                     state_d = S_LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  run_d = 4'd1;
               end
            end
            default: begin
               // Flywheel: a bad sample is taken as one corrupted value, so keep counting.
               expected_d = expected_q + DATA_ONE;
               if (match) begin
                  miss_d = '0;
               end else begin
                  err_pulse_d = 1'b1;
                  if (err_count_q != {ERR_W{1'b1}}) begin
                     err_count_d = err_count_q + ERR_ONE;
                  end
                  miss_d = miss_q + 4'd1;
                  if (miss_q + 4'd1 == LOSS_C) begin
                     state_d = S_SEARCH;
                     miss_d  = '0;
                     run_d   = '0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_SEARCH;
         expected_q  <= '0;
         run_q       <= '0;
         miss_q      <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         run_q       <= run_d;
         miss_q      <= miss_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   assign state     = state_q;
   assign locked    = (state_q == S_LOCKED);
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign expected  = expected_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Bench for count_stream_checker: two instances (default and a saturation-oriented parameter set)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_count_stream_checker;

   logic       clk;
   logic       rst;
   logic       enable;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_data;

   logic       locked_a, err_pulse_a;
   logic [7:0] err_count_a, expected_a;
   logic [1:0] state_a;
   logic       locked_b, err_pulse_b;
   logic [1:0] err_count_b;
   logic [7:0] expected_b;
   logic [1:0] state_b;

   int vectors    = 0;
   int miscompares = 0;

   count_stream_checker #(.WIDTH(8), .ERR_W(8), .LOCK_LEN(4), .LOSS_LEN(3)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .locked(locked_a), .err_pulse(err_pulse_a), .err_count(err_count_a),
      .expected(expected_a), .state(state_a)
   );

   count_stream_checker #(.WIDTH(8), .ERR_W(2), .LOCK_LEN(4), .LOSS_LEN(15)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .locked(locked_b), .err_pulse(err_pulse_b), .err_count(err_count_b),
      .expected(expected_b), .state(state_b)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural reference: mode 0=search, 1=acquire, 2=locked
   typedef struct packed {
      int   mode;
      int   exp;
      int   run;
      int   miss;
      int   errs;
      logic pulse;
   } model_t;

   model_t ma, mb;

   function automatic model_t model_reset();
      model_t m;
      m.mode = 0; m.exp = 0; m.run = 0; m.miss = 0; m.errs = 0; m.pulse = 1'b0;
      return m;
   endfunction

   function automatic model_t model_step(model_t m, bit en, bit clr, bit v, int d,
                                         int lock_len, int loss_len, int err_max);
      model_t n = m;
      n.pulse = 1'b0;
      if (clr) begin
         n.mode = 0; n.errs = 0; n.run = 0; n.miss = 0;
      end else if (en && v) begin
         if (m.mode == 0) begin
            n.exp = (d + 1) % 256; n.run = 1; n.mode = 1;
         end else if (m.mode == 1) begin
            n.exp = (d + 1) % 256;
            if (d == m.exp) begin
               n.run = m.run + 1;
               if (n.run >= lock_len) begin n.mode = 2; n.miss = 0; end
            end else begin
               n.run = 1;
            end
         end else begin
            n.exp = (m.exp + 1) % 256;
            if (d == m.exp) n.miss = 0;
            else begin
               n.pulse = 1'b1;
               n.errs  = (m.errs < err_max) ? m.errs + 1 : err_max;
               n.miss  = m.miss + 1;
               if (n.miss >= loss_len) begin n.mode = 0; n.miss = 0; n.run = 0; end
            end
         end
      end
      return n;
   endfunction

   // scoreboard check
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, want, $time);
      end
   endtask

   task automatic check_all();
      chk("a_state",  32'(state_a),     32'(ma.mode));
      chk("a_locked", 32'(locked_a),    32'(ma.mode == 2));
      chk("a_pulse",  32'(err_pulse_a), 32'(ma.pulse));
      chk("a_errs",   32'(err_count_a), 32'(ma.errs));
      chk("a_exp",    32'(expected_a),  32'(ma.exp));
      chk("b_state",  32'(state_b),     32'(mb.mode));
      chk("b_locked", 32'(locked_b),    32'(mb.mode == 2));
      chk("b_pulse",  32'(err_pulse_b), 32'(mb.pulse));
      chk("b_errs",   32'(err_count_b), 32'(mb.errs));
      chk("b_exp",    32'(expected_b),  32'(mb.exp));
   endtask

   // driver: called at a falling edge, returns at the next falling edge after checking
   task automatic drive(input bit en, input bit clr, input bit v, input int d);
      enable = en; clear = clr; in_valid = v; in_data = 8'(d);
      @(posedge clk);
      ma = model_step(ma, en, clr, v, d, 4, 3, 255);
      mb = model_step(mb, en, clr, v, d, 4, 15, 3);
      @(negedge clk);
      check_all();
   endtask

   task automatic feed(input int d);
      drive(1'b1, 1'b0, 1'b1, d);
   endtask

   task automatic do_clear();
      drive(1'b1, 1'b1, 1'b0, 0);
   endtask

   initial begin
      int cnt;
      int d;
      bit v, en, clr;
      rst = 1'b1; enable = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      ma = model_reset(); mb = model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all();

      // lock and wrap
      feed(5);
      chk("acq_after_5", 32'(state_a), 32'd1);
      for (int i = 6; i <= 8; i++) feed(i);
      chk("lock_after_8", 32'(locked_a), 32'd1);
      chk("exp_after_8", 32'(expected_a), 32'd9);
      for (int i = 9; i <= 258; i++) feed(i % 256);
      chk("wrap_exp", 32'(expected_a), 32'd3);
      chk("wrap_errs", 32'(err_count_a), 32'd0);
      chk("wrap_locked", 32'(locked_a), 32'd1);

      // async reset mid-stream, no clock edge
      @(posedge clk); #2;
      rst = 1'b1; #1;
      ma = model_reset(); mb = model_reset();
      chk("rst_state", 32'(state_a), 32'd0);
      chk("rst_locked", 32'(locked_a), 32'd0);
      chk("rst_errs", 32'(err_count_a), 32'd0);
      chk("rst_pulse", 32'(err_pulse_a), 32'd0);
      chk("rst_exp", 32'(expected_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) drive(1'b1, 1'b0, 1'b0, 0);

      // single glitch
      for (int i = 6; i <= 11; i++) feed(i);
      feed(99);
      chk("glitch_pulse", 32'(err_pulse_a), 32'd1);
      feed(13);
      chk("glitch_pulse_off", 32'(err_pulse_a), 32'd0);
      feed(14);
      chk("glitch_errs", 32'(err_count_a), 32'd1);
      chk("glitch_locked", 32'(locked_a), 32'd1);
      chk("glitch_exp", 32'(expected_a), 32'd15);

      // loss of lock
      do_clear();
      for (int i = 16; i <= 19; i++) feed(i);
      feed(50); chk("loss_p1", 32'(err_pulse_a), 32'd1);
      feed(60); chk("loss_p2", 32'(err_pulse_a), 32'd1);
      feed(70); chk("loss_p3", 32'(err_pulse_a), 32'd1);
      chk("loss_errs", 32'(err_count_a), 32'd3);
      chk("loss_state", 32'(state_a), 32'd0);
      for (int i = 71; i <= 74; i++) feed(i);
      chk("relock", 32'(locked_a), 32'd1);
      chk("relock_errs", 32'(err_count_a), 32'd3);

      // acquire re-seed
      do_clear();
      feed(1); feed(2); feed(40); feed(41); feed(42); feed(43);
      chk("reseed_locked", 32'(locked_a), 32'd1);
      chk("reseed_exp", 32'(expected_a), 32'd44);
      chk("reseed_errs", 32'(err_count_a), 32'd0);

      // saturation (instance b) and clear priority
      do_clear();
      for (int i = 5; i <= 8; i++) feed(i);
      repeat (5) feed(200);
      chk("sat_errs_b", 32'(err_count_b), 32'd3);
      chk("sat_locked_b", 32'(locked_b), 32'd1);
      drive(1'b1, 1'b1, 1'b1, 77);
      chk("clr_errs_b", 32'(err_count_b), 32'd0);
      chk("clr_state_b", 32'(state_b), 32'd0);
      chk("clr_exp_b", 32'(expected_b), 32'd14);
      drive(1'b0, 1'b0, 1'b1, 33);
      drive(1'b0, 1'b0, 1'b1, 34);
      chk("en_off_state", 32'(state_b), 32'd0);

      // randomized stream
      cnt = $urandom_range(0, 255);
      for (int i = 0; i < 3000; i++) begin
         en  = ($urandom_range(0, 19) != 0);
         clr = ($urandom_range(0, 299) == 0);
         v   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) cnt = $urandom_range(0, 255);
         d = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 255)) : cnt;
         drive(en, clr, v, d);
         if (en && v && !clr) cnt = (cnt + 1) % 256;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receive end of the counter output stream: samples a free-running WIDTH-bit count bus and checks that each valid sample equals the previous sample + 1, with wrap modulo 2^WIDTH.
- Locks onto the sequence, counts sequence errors, and reports loss of lock.
- Sits on the consumer side of the counter's output pins; also serves as an on-chip self-check monitor.

Parameters:
- WIDTH, 8, width of the count bus being checked
- ERR_W, 8, width of the saturating error counter
- LOCK_LEN, 4, consecutive in-sequence samples (seed included) required to lock; legal range 2..15
- LOSS_LEN, 3, consecutive mismatches while locked that drop lock; legal range 1..15

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  when low, in_valid is ignored and all state holds
- clear  input  1  synchronous: err_count←0, state←SEARCH; priority over in_valid
- in_valid  input  1  in_data is sampled this cycle (qualified by enable)
- in_data  input  WIDTH  count value under check
- locked  output  1  high while state is LOCKED
- err_pulse  output  1  one-cycle pulse for each mismatch detected while LOCKED
- err_count  output  ERR_W  saturating mismatch count (LOCKED mismatches only)
- expected  output  WIDTH  next value the checker expects
- state  output  2  SEARCH=0, ACQUIRE=1, LOCKED=2

Behaviour:
- Reset (async, rst=1):
  - state=SEARCH, locked=0, err_pulse=0, err_count=0, expected=0.
  - Internal run and miss counters = 0.
  - Reset takes effect immediately, with no clock edge, in any state.
- All outputs are registered. A sample accepted on edge N is reflected in the outputs after edge N. err_pulse is high for exactly the cycle following the offending edge.
- Accept condition: enable & in_valid & ~clear.
- Match: in_data == expected. All arithmetic is modulo 2^WIDTH, so 2^WIDTH-1 → 0 is a match.
- SEARCH, on accept:
  - expected←in_data+1, run←1, state→ACQUIRE.
- ACQUIRE, on accept:
  - Match: expected←in_data+1, run←run+1. If run+1==LOCK_LEN, state→LOCKED and miss←0.
  - Mismatch: re-seed with expected←in_data+1, run←1; stay in ACQUIRE.
  - No error counting and no err_pulse in this state.
- LOCKED, on accept:
  - Match: expected←expected+1, miss←0.
  - Mismatch:
    - err_pulse←1.
    - err_count←err_count+1, saturating at 2^ERR_W-1.
    - expected←expected+1 (flywheel: the bad sample is treated as a single corrupted value).
    - miss←miss+1. If miss+1==LOSS_LEN, state→SEARCH and locked←0.
- No accept in a cycle:
  - err_pulse←0; all other state holds.
  - Gaps in in_valid do not count as errors.
- clear:
  - Forces state=SEARCH, err_count=0, err_pulse=0, run=0, miss=0, regardless of in_valid.
  - expected holds its value.
- enable=0 with clear=1: clear still applies.
- Unused 2-bit state encoding 3: next edge → SEARCH.
- locked is derived only from the registered state (==LOCKED); there is no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst mid-stream without a clock edge → state=0, locked=0, err_count=0, err_pulse=0, expected=0 immediately; release, no valids → outputs hold.
- Lock + wrap: valids 5,6,7,8 → state ACQUIRE after 5, locked=1 after the edge of 8, expected=9. Continue 9..255,0,1,2 → err_count stays 0, locked stays 1, expected=3.
- Single glitch: locked at expected=10; feed 10,11,99,13,14 → err_pulse high exactly one cycle after 99, err_count=1, locked stays 1, expected=15.
- Loss of lock (LOSS_LEN=3): locked at expected=20; feed 50,60,70 → err_pulse on three consecutive cycles, err_count=3, state=SEARCH after 70. Then 71,72,73,74 → relock, err_count still 3.
- ACQUIRE re-seed: from SEARCH feed 1,2,40,41,42,43 → no err_pulse, err_count=0, locked=1 after 43, expected=44.
- Saturation and clear: ERR_W=2, locked, LOSS_LEN=15; feed 5 mismatches → err_count=3 (saturated). Then clear=1 together with in_valid=1 → err_count=0, state=SEARCH, in_data not captured. enable=0 with valids → nothing changes.
